// File: rtl/fifo_merge_pkg.sv
// Shared constants and the round-robin search used by the merge-tree nodes.
package fifo_merge_pkg;

    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_DEPTH      = 32;
    localparam int DEF_NUM_CH     = 2;

    localparam int RR_MAX_CH   = 16;
    localparam int RR_IDX_BITS = 4;

    // First requester after 'last', wrapping; returns 'last' when nothing requests.
    // Unused upper request bits are zero, so wrapping over RR_MAX_CH equals wrapping over NUM_CH.
    function automatic logic [RR_IDX_BITS-1:0] next_rr(
        input logic [RR_IDX_BITS-1:0] last,
        input logic [RR_MAX_CH-1:0]   req
    );
        logic [RR_IDX_BITS-1:0] idx;
        next_rr = last;
        for (int i = RR_MAX_CH; i >= 1; i--) begin
            idx = last + i[RR_IDX_BITS-1:0];
            if (req[idx]) begin
                next_rr = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_merge_chan.sv
// One ingress channel: circular buffer with exact occupancy and full/empty/almost-full flags.
module fifo_merge_chan
    import fifo_merge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEF_DEPTH - 4,
    parameter int PTR_BITS   = $clog2(DEPTH),
    parameter int CNT_BITS   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_BITS-1:0]   count,
    output logic                  empty,
    output logic                  almost_full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        push_ready  = (count != CNT_BITS'(DEPTH));
        empty       = (count == '0);
        almost_full = (count >= CNT_BITS'(AF_LEVEL));
        do_push     = push_valid && push_ready;
        do_pop      = pop && !empty;
        pop_data    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_merge_buffer.sv
// Multi-channel FIFO bank merged round-robin into one registered egress port.
// Define FIFO_MERGE_CHAN_TAG_EN to add the out_chan source-channel tag.
module fifo_merge_buffer
    import fifo_merge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int PTR_BITS   = $clog2(DEPTH),
    parameter int CNT_BITS   = $clog2(DEPTH) + 1,
    parameter int CH_BITS    = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
`ifdef FIFO_MERGE_CHAN_TAG_EN
    output logic [CH_BITS-1:0]           out_chan,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*CNT_BITS-1:0]   count_o,
    output logic [NUM_CH-1:0]            empty_o,
    output logic [NUM_CH-1:0]            almost_full_o
);

    logic [DATA_WIDTH-1:0] chan_data [NUM_CH];
    logic [NUM_CH-1:0]     chan_pop;
    logic [NUM_CH-1:0]     req;
    logic [CH_BITS-1:0]    last_grant;
    logic [CH_BITS-1:0]    grant;
    logic                  out_free;
    logic                  any_req;
    logic                  do_grant;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        fifo_merge_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (AF_LEVEL),
            .PTR_BITS   (PTR_BITS),
            .CNT_BITS   (CNT_BITS)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .push_data   (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .push_valid  (in_valid[c]),
            .push_ready  (in_ready[c]),
            .pop         (chan_pop[c]),
            .pop_data    (chan_data[c]),
            .count       (count_o[c*CNT_BITS +: CNT_BITS]),
            .empty       (empty_o[c]),
            .almost_full (almost_full_o[c])
        );
    end

    // A pop happens only when the egress register can take the word this edge.
    always_comb begin
        out_free = !out_valid || out_ready;
        req      = ~empty_o;
        any_req  = |req;
        grant    = CH_BITS'(next_rr(RR_IDX_BITS'(last_grant), RR_MAX_CH'(req)));
        do_grant = out_free && any_req;
        chan_pop = '0;
        if (do_grant) begin
            chan_pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= CH_BITS'(NUM_CH - 1);
`ifdef FIFO_MERGE_CHAN_TAG_EN
            out_chan   <= '0;
`endif
        end else if (out_free) begin
            out_valid <= any_req;
            if (any_req) begin
                out_data   <= chan_data[grant];
                last_grant <= grant;
`ifdef FIFO_MERGE_CHAN_TAG_EN
                out_chan   <= grant;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fifo_merge_buffer.sv
// Scoreboard bench for fifo_merge_buffer: directed stimulus queues expected egress words, a monitor checks them.
module tb_fifo_merge_buffer;

    localparam int DW   = 36;
    localparam int DEP  = 32;
    localparam int NCH  = 2;
    localparam int CNTB = 6;

    typedef struct packed {
        logic [0:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NCH*DW-1:0]     in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [DW-1:0]         out_data;
`ifdef FIFO_MERGE_CHAN_TAG_EN
    logic [0:0]            out_chan;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*CNTB-1:0]   count_o;
    logic [NCH-1:0]        empty_o;
    logic [NCH-1:0]        almost_full_o;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    fifo_merge_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
`ifdef FIFO_MERGE_CHAN_TAG_EN
        .out_chan      (out_chan),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNTB-1:0] cnt(input int c);
        return count_o[c*CNTB +: CNTB];
    endfunction

    task automatic drive(input int ch, input logic [DW-1:0] data);
        in_valid[ch] = 1'b1;
        in_data[ch*DW +: DW] = data;
    endtask

    task automatic expect_word(input int ch, input logic [DW-1:0] data);
        exp_t e;
        e.ch   = ch[0:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
        end
    endtask

    // Egress monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL egress_unexpected: got %0h with nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                check("egress_data", out_data, e.data);
`ifdef FIFO_MERGE_CHAN_TAG_EN
                check("egress_chan", out_chan, e.ch);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CNTB-1:0] exp_cnt;

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 2'b11);
        check("rst_af", almost_full_o, 2'b00);
        check("rst_in_ready", in_ready, 2'b11);
`ifdef FIFO_MERGE_CHAN_TAG_EN
        check("rst_out_chan", out_chan, 0);
`endif
        reset = 1'b0;
        tick();

        // Single channel stream 1..5 with egress always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            expect_word(0, DW'(i));
            drive(0, DW'(i));
            tick();
            in_valid = '0;
            if (i == 1) check("lat_not_yet", out_valid, 0);
            if (i == 2) check("lat_valid", out_valid, 1);
        end
        repeat (4) tick();
        check("t1_count0", cnt(0), 0);
        drain("t1_drain");

        // Fill channel 1 with egress stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (k <= 33) expect_word(1, 36'h200 + DW'(k));
            drive(1, 36'h200 + DW'(k));
            tick();
            in_valid = '0;
            exp_cnt = (k == 1) ? 6'd1 : ((k - 1 > 32) ? 6'd32 : CNTB'(k - 1));
            check("fill_count", cnt(1), exp_cnt);
            check("fill_in_ready", in_ready[1], exp_cnt != 6'd32);
            check("fill_af", almost_full_o[1], exp_cnt >= 6'd28);
        end
        check("fill_ch0_empty", cnt(0), 0);
        out_ready = 1'b1;
        drain("fill_drain");
        check("fill_count_after", cnt(1), 0);

        // Two channels stalled: first grant to channel 0, hold stable, then alternate
        out_ready = 1'b0;
        expect_word(0, 36'h100);
        expect_word(1, 36'h300);
        expect_word(0, 36'h101);
        expect_word(1, 36'h301);
        expect_word(0, 36'h102);
        expect_word(1, 36'h302);
        expect_word(1, 36'h303);
        for (int i = 0; i < 3; i++) begin
            drive(0, 36'h100 + DW'(i));
            drive(1, 36'h300 + DW'(i));
            tick();
            in_valid = '0;
        end
        check("rr_first_data", out_data, 36'h100);
        check("rr_cnt0", cnt(0), 2);
        check("rr_cnt1", cnt(1), 3);
        for (int s = 0; s < 5; s++) begin
            if (s == 0) drive(1, 36'h303);
            tick();
            in_valid = '0;
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 36'h100);
            check("stall_cnt0", cnt(0), 2);
            check("stall_cnt1", cnt(1), 4);
        end
        out_ready = 1'b1;
        drain("rr_drain");

        // Push and pop channel 0 every cycle across pointer wraps
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_word(0, 36'h400 + DW'(k));
            drive(0, 36'h400 + DW'(k));
            tick();
            in_valid = '0;
        end
        check("wrap_pre_count", cnt(0), 3);
        out_ready = 1'b1;
        for (int k = 4; k < 4 + 3*DEP; k++) begin
            expect_word(0, 36'h400 + DW'(k));
            drive(0, 36'h400 + DW'(k));
            tick();
            in_valid = '0;
            check("wrap_count", cnt(0), 3);
        end
        drain("wrap_drain");

        // Reset while data is held
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 36'h500 + DW'(i));
            drive(1, 36'h600 + DW'(i));
            tick();
        end
        reset = 1'b1;
        drive(0, 36'h5ff);
        drive(1, 36'h6ff);
        tick();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_count", count_o, 0);
        check("mrst_in_ready", in_ready, 2'b11);
        check("mrst_empty", empty_o, 2'b11);
        reset = 1'b0;
        in_valid = '0;
        tick();
        check("mrst_count_after", count_o, 0);
        check("mrst_valid_after", out_valid, 0);

        // After reset channel 0 is served first
        out_ready = 1'b1;
        expect_word(0, 36'h700);
        expect_word(1, 36'h800);
        drive(0, 36'h700);
        drive(1, 36'h800);
        tick();
        in_valid = '0;
        drain("post_rst_drain");
        check("final_count", count_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_merge_buffer.md
# fifo_merge_buffer

Multi-channel FIFO bank with a round-robin merge stage, the building block of the next FIFO tree. Each of NUM_CH ingress channels owns an independent circular buffer of DEPTH entries with valid/ready flow control and an exact occupancy count. One registered egress port drains the channels in round-robin order. It replaces single-channel buffers at each tree node so a node merges its children in one block.

## Interface
- DATA_WIDTH, 36: payload bits per entry.
- DEPTH, 32: entries per channel; power of two, ≥2.
- NUM_CH, 2: ingress channels, ≥2.
- AF_LEVEL, DEPTH-4: almost-full threshold, 1..DEPTH.
- PTR_BITS, $clog2(DEPTH): derived pointer width.
- CNT_BITS, $clog2(DEPTH)+1: derived count width, holds 0..DEPTH.
- CH_BITS, $clog2(NUM_CH): derived channel index width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_CH  per-channel write request.
- in_ready  out  NUM_CH  per-channel space available.
- out_data  out  DATA_WIDTH  egress payload.
- out_chan  out  CH_BITS  source channel of out_data; present only with FIFO_MERGE_CHAN_TAG_EN.
- out_valid  out  1  egress holds valid data.
- out_ready  in  1  downstream accepts.
- count_o  out  NUM_CH*CNT_BITS  per-channel occupancy, output register excluded.
- empty_o  out  NUM_CH  count==0.
- almost_full_o  out  NUM_CH  count≥AF_LEVEL.

## Operation
- Push on channel c: in_valid[c] && in_ready[c] at an edge. in_ready[c] = (count[c] != DEPTH). This is combinational from count only and never depends on out_ready.
- Full means count==DEPTH. All DEPTH entries are usable.
- Pops are internal. The output register is "free" when !out_valid || out_ready. When it is free, the arbiter grants the first channel with count>0, searching from last_grant+1 modulo NUM_CH. The granted entry is loaded into out_data at the edge, and last_grant updates to that channel.
- No grant occurs when every count is 0. out_valid then drops if the output was consumed.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance. A full channel does not accept a push in the same cycle it is popped, because in_ready is already low.
- Pointers wrap modulo DEPTH naturally.
- No empty bypass. A pushed word always passes through its buffer.
- With out_valid && !out_ready, out_data, out_chan and out_valid hold stable. No pop occurs.

## Timing
- Reset values: out_valid 0, out_data 0, out_chan 0, all counts 0, empty_o all 1, almost_full_o all 0, in_ready all 1. last_grant = NUM_CH-1, so channel 0 is served first. Pointers 0. Buffer contents are not cleared.
- Latency: a word pushed at edge E into an empty channel, with the output free, appears with out_valid=1 after edge E+1.
- Throughput: one egress word per cycle while out_ready=1 and any channel is non-empty.
- count_o, empty_o and almost_full_o reflect state after the last edge. They are registered or derived from registered state.
- Reset asserted mid-operation discards all stored and in-flight data on the next edge. Pushes in the reset cycle are ignored.

## Configuration
- FIFO_MERGE_CHAN_TAG_EN defined: out_chan port exists. It is loaded with the granted channel index together with out_data, and holds while stalled.
- Not defined: out_chan port and its register are absent. Egress carries payload only. All other behaviour is identical.

## Structure
- Package fifo_merge_pkg: default DATA_WIDTH, DEPTH and NUM_CH constants, plus a next_rr(last, req) round-robin function shared with later tree nodes.
- Sub-module fifo_merge_chan: one circular buffer. It contains memory, read and write pointers, the count, and the push/pop/ready/empty/almost-full logic. It is instantiated NUM_CH times via generate.
- The top level holds the arbiter, last_grant and the egress register.

## Test plan
- Reset, then push 0x1..0x5 on channel 0 with out_ready=1: out_data is 0x1..0x5 in order, first out_valid two edges after the first push, and count_o[0] returns to 0.
- Fill channel 1 with 32 words while out_ready=0 (one word sits in the egress register, so the channel reaches full after 33 pushes): in_ready[1]=0 at count 32, and almost_full_o[1] rises at count 28. The 34th push attempt is not accepted.
- Hold both channels non-empty with out_ready=1: out_chan alternates 0,1,0,1 and the first grant goes to channel 0.
- Stall out_ready=0 for 5 cycles with a valid output: out_data and out_valid stay constant, and counts are unchanged except for pushes.
- Push and pop the same channel every cycle for 3*DEPTH cycles: count stays constant, pointers wrap, and data order is preserved.
- Assert reset while channels hold data: the next cycle shows out_valid=0, all counts 0, and all in_ready=1.
